lane_to_fifo_bridge: RTL

//  Receive-side counterpart of the FIFO-to-lane bridge: takes the byte stream from one lane receiver
//  (burst start/end strobes, byte valid, LP/HS mode) and packs it into 36-bit words for the RX FIFO.

---
 rtl/lane_to_fifo_bridge_if.sv | 25 ++
 rtl/lane_to_fifo_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_to_fifo_bridge_if.sv
// Lane-receiver byte stream and RX FIFO write port of the lane-to-FIFO bridge.
// The master side drives the lane and reports FIFO fullness; the bridge is the slave.
interface lane_to_fifo_bridge_if;
    // Handshake: the lane cannot be stalled, so rx_start/rx_valid/rx_end are single-cycle
    // qualifiers with no ready. A FIFO word transfers in every cycle with fifo_write=1;
    // fifo_write never asserts while fifo_full=1 (that word is dropped, not retried).
    logic        rx_start;
    logic        rx_mode_lp;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_end;
    logic        fifo_full;
    logic        fifo_write;
    logic [35:0] fifo_data;

    modport master (
        output rx_start, rx_mode_lp, rx_valid, rx_data, rx_end, fifo_full,
        input  fifo_write, fifo_data
    );

    modport slave (
        input  rx_start, rx_mode_lp, rx_valid, rx_data, rx_end, fifo_full,
        output fifo_write, fifo_data
    );
endinterface

// File: rtl/lane_to_fifo_bridge.sv
// Packs lane RX bytes into 36-bit RX FIFO words {mode_lp, last, cnt, data[31:0]},
// with an idle watchdog, drop-on-full and sticky error status.
module lane_to_fifo_bridge #(
    parameter int TO_W   = 16,
    parameter int DROP_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lane_to_fifo_bridge_if.slave bus,
    input  logic [TO_W-1:0]      rx_timeout,
    input  logic                 err_clr,
    output logic                 overflow_err,
    output logic                 timeout_err,
    output logic                 proto_err,
    output logic [DROP_W-1:0]    dropped_cnt,
    output logic                 dbg_state_o
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [TO_W-1:0]   ctr_q, ctr_d;
    logic [35:0]       fin_q, fin_d;
    logic              fin_vld_q, fin_vld_d;
    logic [35:0]       out_q, out_d;
    logic              wr_q, wr_d;
    logic [35:0]       held_q, held_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              proto_q, proto_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              active;
    logic              take_byte;
    logic              word_done;
    logic              flush;
    logic              fire;
    logic              restart;
    logic              closing;
    logic [31:0]       asm_b;
    logic [1:0]        idx_b;
    logic              fin_have;
    logic [35:0]       fin_word;
    logic [35:0]       flush_word;
    logic [35:0]       w0;
    logic [35:0]       w1;
    logic [1:0]        new_cnt;
    logic              write_now;
    logic              drop_now;
    logic [DROP_W-1:0] drop_base;

    // Event decode for the current cycle; a byte arriving with a close is packed first.
    always_comb begin
        active    = (state_q == ST_ACTIVE);
        take_byte = active & bus.rx_valid;
        fire      = active & ~bus.rx_valid & (rx_timeout != '0) & (ctr_q <= TO_W'(1));
        restart   = active & bus.rx_start;
        closing   = active & (bus.rx_end | fire | bus.rx_start);

        asm_b = asm_q;
        if (take_byte) begin
            asm_b[{idx_q, 3'b000} +: 8] = bus.rx_data;
        end
        idx_b      = take_byte ? idx_q + 2'd1 : idx_q;
        word_done  = take_byte & (idx_q == 2'd3);
        flush      = take_byte & pend_vld_q;
        flush_word = {mode_q, 1'b0, 2'd3, pend_q};

        fin_have = 1'b0;
        fin_word = '0;
        if (closing) begin
            if (idx_b != 2'd0) begin
                fin_have = 1'b1;
                fin_word = {mode_q, 1'b1, idx_b - 2'd1, asm_b};
            end else if (word_done) begin
                fin_have = 1'b1;
                fin_word = {mode_q, 1'b1, 2'd3, asm_b};
            end else if (pend_vld_q) begin
                fin_have = 1'b1;
                fin_word = {mode_q, 1'b1, 2'd3, pend_q};
            end
        end

        w0      = flush ? flush_word : fin_word;
        w1      = fin_word;
        new_cnt = {1'b0, flush} + {1'b0, fin_have};
    end

    // One write per cycle: a deferred word always goes out before anything new.
    always_comb begin
        wr_d      = 1'b0;
        out_d     = out_q;
        fin_d     = fin_q;
        fin_vld_d = 1'b0;
        if (fin_vld_q) begin
            wr_d  = 1'b1;
            out_d = fin_q;
            if (new_cnt != 2'd0) begin
                fin_d     = w0;
                fin_vld_d = 1'b1;
            end
        end else if (new_cnt != 2'd0) begin
            wr_d  = 1'b1;
            out_d = w0;
            if (new_cnt == 2'd2) begin
                fin_d     = w1;
                fin_vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        asm_d      = asm_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ctr_d      = ctr_q;
        if (!active) begin
            if (bus.rx_start) begin
                state_d    = ST_ACTIVE;
                mode_d     = bus.rx_mode_lp;
                asm_d      = '0;
                idx_d      = 2'd0;
                pend_vld_d = 1'b0;
                ctr_d      = rx_timeout;
            end
        end else if (closing) begin
            asm_d      = '0;
            idx_d      = 2'd0;
            pend_vld_d = 1'b0;
            ctr_d      = rx_timeout;
            if (restart) begin
                mode_d = bus.rx_mode_lp;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            asm_d = word_done ? '0 : asm_b;
            idx_d = idx_b;
            if (word_done) begin
                pend_d     = asm_b;
                pend_vld_d = 1'b1;
            end else if (flush) begin
                pend_vld_d = 1'b0;
            end
            if (take_byte) begin
                ctr_d = rx_timeout;
            end else if (ctr_q != '0) begin
                ctr_d = ctr_q - TO_W'(1);
            end
        end
    end

    // A full FIFO swallows the word; a simultaneous error event beats err_clr.
    always_comb begin
        write_now = wr_q & ~bus.fifo_full;
        drop_now  = wr_q & bus.fifo_full;
        held_d    = write_now ? out_q : held_q;
        ovf_d     = (ovf_q & ~err_clr) | drop_now;
        tmo_d     = (tmo_q & ~err_clr) | fire;
        proto_d   = (proto_q & ~err_clr) | restart;
        drop_base = err_clr ? '0 : drop_q;
        drop_d    = (drop_now && (drop_base != '1)) ? drop_base + DROP_W'(1) : drop_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            asm_q      <= '0;
            idx_q      <= 2'd0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ctr_q      <= '0;
            fin_q      <= '0;
            fin_vld_q  <= 1'b0;
            out_q      <= '0;
            wr_q       <= 1'b0;
            held_q     <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            proto_q    <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            asm_q      <= asm_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ctr_q      <= ctr_d;
            fin_q      <= fin_d;
            fin_vld_q  <= fin_vld_d;
            out_q      <= out_d;
            wr_q       <= wr_d;
            held_q     <= held_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            proto_q    <= proto_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.fifo_write = write_now;
    assign bus.fifo_data  = write_now ? out_q : held_q;
    assign overflow_err   = ovf_q;
    assign timeout_err    = tmo_q;
    assign proto_err      = proto_q;
    assign dropped_cnt    = drop_q;
    assign dbg_state_o    = state_q[0];
endmodule
